// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and line-level constants
// common to the transmit and receive sides.
package uart_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } rx_state_t;

   localparam logic LINE_IDLE = 1'b1;
   localparam logic START_BIT = 1'b0;
   localparam logic STOP_BIT  = 1'b1;

endpackage

// File: rtl/uart_rx_sync2.sv
// Two-flop synchronizer for a single asynchronous line; resets to the idle
// (high) level so a reset never looks like a start bit.
module sync2
   import uart_pkg::*;
(
   input  logic RXC,
   input  logic RST,
   input  logic D,
   output logic Q
);

   logic s1_q, s2_q;

   always_ff @(posedge RXC) begin
      if (RST) begin
         s1_q <= LINE_IDLE;
         s2_q <= LINE_IDLE;
      end else begin
         s1_q <= D;
         s2_q <= s1_q;
      end
   end

   assign Q = s2_q;

endmodule

// File: rtl/uart_rx.sv
// Oversampling UART receiver: start bit, SIZE data bits LSB first, one stop
// bit. Good words land on RXDATA with a one-cycle RX_VALID; bad stop bits pulse RX_ERR.
module uart_rx
   import uart_pkg::*;
#(
   parameter int SIZE       = 8,
   parameter int OVERSAMPLE = 16
) (
   input  logic            RXC,
   input  logic            RST,
   input  logic            RXD,
   output logic [SIZE-1:0] RXDATA,
   output logic            RX_VALID,
   output logic            RX_ERR,
   output logic            RX_BUSY
);

   localparam int CW = $clog2(OVERSAMPLE);
   localparam int IW = $clog2(SIZE + 1);
   localparam logic [CW-1:0] HALF_M1  = CW'(OVERSAMPLE / 2 - 1);
   localparam logic [CW-1:0] FULL_M1  = CW'(OVERSAMPLE - 1);
   localparam logic [IW-1:0] LAST_IDX = IW'(SIZE - 1);

   logic            rxd_s;
   logic            prev_q, prev_d;
   rx_state_t       state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [IW-1:0]   idx_q, idx_d;
   logic [SIZE-1:0] shift_q, shift_d;
   logic [SIZE-1:0] data_q, data_d;
   logic            valid_q, valid_d;
   logic            err_q, err_d;
   logic            busy_q, busy_d;
   logic            fall;
   logic [SIZE:0]   shift_in;

   sync2 u_sync (
      .RXC (RXC),
      .RST (RST),
      .D   (RXD),
      .Q   (rxd_s)
   );

   // Only a true 1->0 transition starts a frame; a line stuck low does not.
   assign fall     = prev_q && !rxd_s;
   assign shift_in = {rxd_s, shift_q};

   always_comb begin
      prev_d  = rxd_s;
      state_d = state_q;
      cnt_d   = cnt_q + 1'b1;
      idx_d   = idx_q;
      shift_d = shift_q;
      data_d  = data_q;
      valid_d = 1'b0;
      err_d   = 1'b0;

      case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (fall) state_d = START;
         end
         START: begin
            if (cnt_q == HALF_M1) begin
               cnt_d = '0;
               idx_d = '0;
               state_d = (rxd_s == START_BIT) ? DATA : IDLE;
            end
         end
         DATA: begin
            if (cnt_q == FULL_M1) begin
               cnt_d   = '0;
               shift_d = shift_in[SIZE:1];
               idx_d   = idx_q + 1'b1;
               if (idx_q == LAST_IDX) state_d = STOP;
            end
         end
         STOP: begin
            if (cnt_q == FULL_M1) begin
               cnt_d   = '0;
               state_d = IDLE;
               if (rxd_s == STOP_BIT) begin
                  data_d  = shift_q;
                  valid_d = 1'b1;
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase

      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge RXC) begin
      if (RST) begin
         prev_q  <= LINE_IDLE;
         state_q <= IDLE;
         cnt_q   <= '0;
         idx_q   <= '0;
         shift_q <= '0;
         data_q  <= '0;
         valid_q <= 1'b0;
         err_q   <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         prev_q  <= prev_d;
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         shift_q <= shift_d;
         data_q  <= data_d;
         valid_q <= valid_d;
         err_q   <= err_d;
         busy_q  <= busy_d;
      end
   end

   assign RXDATA   = data_q;
   assign RX_VALID = valid_q;
   assign RX_ERR   = err_q;
   assign RX_BUSY  = busy_q;

endmodule

// File: doc/uart_rx.md
# uart_rx

Serial receiver consuming the line driven by the `TX` block's `TXD` output. It is the downstream stage of the transmitter in loopback and in link configurations. It oversamples the asynchronous `RXD` line and recovers one frame: start bit, `SIZE` data bits LSB first, one stop bit. Each received word is presented on a parallel register with a one-cycle valid pulse, or a one-cycle framing-error pulse.

## Interface
- `SIZE`, 8, data bits per frame; must match the `TX` instance's `SIZE`.
- `OVERSAMPLE`, 16, `RXC` cycles per bit period; legal range ≥ 4, even.
- `RXC`  input  1  receive clock, `OVERSAMPLE` × bit rate; all logic on rising edge.
- `RST`  input  1  synchronous, active-high reset, sampled on `RXC` rising edge.
- `RXD`  input  1  serial line, idle high; asynchronous to `RXC`.
- `RXDATA`  output  `SIZE`  last correctly framed word; holds until the next good frame.
- `RX_VALID`  output  1  one-cycle pulse: `RXDATA` updated this cycle.
- `RX_ERR`  output  1  one-cycle pulse: stop bit sampled low, frame discarded.
- `RX_BUSY`  output  1  high whenever the FSM is not in IDLE.

## Operation
- Frame format:
  - idle = 1;
  - start = 0;
  - `SIZE` data bits, bit 0 first;
  - stop = 1.
- Input conditioning:
  - `RXD` passes through a 2-flop synchronizer; both flops reset to 1.
  - A third flop holds the previous synchronized value (reset 1).
  - Falling edge = previous 1 and synchronized 0.
- Bit-timing counter: width `$clog2(OVERSAMPLE)`. Bit index counter: width `$clog2(SIZE+1)`.
- FSM states `IDLE`, `START`, `DATA`, `STOP`:
  - `IDLE`: on falling edge → `START`, counter ← 0. A line held low (e.g. after an error) never restarts reception; a new 1→0 transition is required.
  - `START`: at counter = `OVERSAMPLE/2-1`, sample mid-bit.
    - 1 → `IDLE`: glitch, no outputs.
    - 0 → `DATA`: counter ← 0, index ← 0.
  - `DATA`: at counter = `OVERSAMPLE-1`, shift sample into shift register MSB (shift right). Index increments.
    - After the `SIZE`-th sample → `STOP`, counter ← 0.
  - `STOP`: at counter = `OVERSAMPLE-1`, sample, then → `IDLE`.
    - 1: `RXDATA` ← shift register, `RX_VALID` ← 1.
    - 0: `RX_ERR` ← 1; `RXDATA` unchanged.
- `RX_VALID` and `RX_ERR` are registered, mutually exclusive, and high for exactly one cycle.
- No flow control: an unread word is overwritten by the next good frame.
- Reset values: `RXDATA` = 0, `RX_VALID` = 0, `RX_ERR` = 0, `RX_BUSY` = 0, FSM = `IDLE`, counters = 0.
- `RST` asserted mid-frame: the partial frame is dropped and no pulse is produced. Reception resumes only on a fresh falling edge after `RST` deasserts.

## Timing
- Let cycle E be the rising edge at which the falling edge is detected. E is 3 `RXC` edges after `RXD` falls, given setup is met.
- Start sample at E + `OVERSAMPLE/2`.
- Data bit k (0..`SIZE-1`) sampled at E + `OVERSAMPLE/2` + (k+1)·`OVERSAMPLE`.
- Stop sample at E + `OVERSAMPLE/2` + (`SIZE`+1)·`OVERSAMPLE`.
  - `RX_VALID`/`RX_ERR` are high in the cycle following that edge.
  - `RX_BUSY` falls in the same cycle.
- `RX_BUSY` rises the cycle after E.
- Back-to-back frames: a start bit immediately after the stop bit is accepted. The FSM is in `IDLE` by mid-stop and detects the next edge.
- Defaults (`SIZE`=8, `OVERSAMPLE`=16): stop sampled at E+152.

## Structure
- Shared package `uart_pkg`:
  - `rx_state_t` enum (`IDLE`, `START`, `DATA`, `STOP`);
  - constants `LINE_IDLE` = 1, `START_BIT` = 0, `STOP_BIT` = 1 (also usable by `TX`).
- Sub-module `sync2`: parameterless 2-flop synchronizer with `RXC`, `RST`, reset-to-1 output. Instantiated once for `RXD`.
- Top `uart_rx`: edge detect, counters, shift register, FSM, output registers.

## Test plan
- Reset: hold `RST` 3 cycles with `RXD` = 1 → all outputs 0, `RX_BUSY` = 0. `RST` asserted for 1 cycle while `RX_VALID` is high → pulse cleared next cycle.
- Single frame 0xA5 at 16 clocks/bit → `RXDATA` = 0xA5, `RX_VALID` one cycle at E+153, `RX_ERR` = 0 throughout.
- Back-to-back frames 0xAA, 0xCC with no idle gap → two `RX_VALID` pulses exactly 160 cycles apart, with `RXDATA` = 0xAA then 0xCC.
- Glitch: `RXD` low for 4 cycles, then high → `RX_BUSY` high from E+1 to E+8, no `RX_VALID`/`RX_ERR`, `RXDATA` unchanged.
- Framing error: frame 0x3C with stop bit 0, line held low 3 bit times → one `RX_ERR` pulse, `RXDATA` keeps the prior value 0xCC, and no restart until `RXD` returns high and falls again.
- Reset mid-frame: `RST` for 1 cycle after data bit 3 of 0x5A → no pulse. A following frame 0x81 is received correctly.
